// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU command scheduler: operator and data-type
// codes, result error codes, FSM state encoding, the queued command layout and
// a legality check used by the issue decode.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  localparam logic [3:0] DT_SIGNED   = 4'h1;
  localparam logic [3:0] DT_UNSIGNED = 4'h2;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_ILL  = 2'd1;
  localparam logic [1:0] ERR_DIV0 = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    OUT    = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  dtype;
    logic [4:0]  op;
    logic [15:0] src1;
    logic [15:0] src2;
  } cmd_t;

  function automatic logic is_legal(input logic [3:0] dtype, input logic [4:0] op);
    return ((dtype == DT_SIGNED) || (dtype == DT_UNSIGNED)) &&
           (op >= OP_ADD) && (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_sched_cmd_fifo.sv
// Synchronous FIFO holding parsed commands.
// Ports: clk, n_rst (async active-low); push/wdata write, pop consumes the
// head shown on rdata; full/empty flags. A pop does not free space for a push
// in the same cycle (full is purely the registered count).
module cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_sched.sv
// Command scheduler between the UART command parser and the hex ALU.
// Ports: cmd_* push side (valid/ready, dtype, op, src1, src2); alu_* issue side
// (start pulse, held operands, done, result); res_* result handshake with
// 2-bit error code; busy and sticky cmd_ovf status. clk, n_rst async low.
// Illegal commands and divide-by-zero are answered without touching the ALU;
// mul/div waits are bounded by TIMEOUT.
module alu_sched
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dtype,
  input  logic [4:0]  cmd_op,
  input  logic [15:0] cmd_src1,
  input  logic [15:0] cmd_src2,
  output logic        alu_start,
  output logic [3:0]  alu_dtype,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  input  logic        alu_done,
  input  logic [31:0] alu_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_err,
  output logic        busy,
  output logic        cmd_ovf
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state_q, state_d;
  cmd_t        opnd_q, opnd_d;
  cmd_t        head, wr_cmd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_err_q, res_err_d;
  logic        cmd_ovf_q, cmd_ovf_d;
  logic        full, empty, pop;

  assign wr_cmd = '{dtype: cmd_dtype, op: cmd_op, src1: cmd_src1, src2: cmd_src2};

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign alu_start = (state_q == ISSUE);
  assign res_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE) || !empty;
  assign alu_dtype = opnd_q.dtype;
  assign alu_op    = opnd_q.op;
  assign alu_src1  = opnd_q.src1;
  assign alu_src2  = opnd_q.src2;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign cmd_ovf   = cmd_ovf_q;

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    pop        = 1'b0;
    cmd_ovf_d  = cmd_ovf_q | (cmd_valid & full);

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          opnd_d = head;
          // Screening decodes the FIFO head directly so error results skip the ALU.
          if (!is_legal(head.dtype, head.op)) begin
            state_d    = OUT;
            res_err_d  = ERR_ILL;
            res_data_d = '0;
          end else if ((head.op == OP_DIV) && (head.src2 == '0)) begin
            state_d    = OUT;
            res_err_d  = ERR_DIV0;
            res_data_d = '1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if ((opnd_q.op == OP_ADD) || (opnd_q.op == OP_SUB)) begin
          state_d = SETTLE;
        end else if (alu_done) begin
          state_d = SETTLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d    = OUT;
          res_err_d  = ERR_TMO;
          res_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        res_data_d = alu_res;
        res_err_d  = ERR_OK;
        state_d    = OUT;
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      opnd_q     <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= '0;
      cmd_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      cmd_ovf_q  <= cmd_ovf_d;
    end
  end

endmodule
